// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in, serial-out frame transmitter.
// Holds the FSM state encoding, the fixed line levels and a width helper.
// Imported by piso_serial_tx and bit_timer.
package piso_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Ceiling log2; returns 0 for value <= 1, callers clamp to a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// BIT_CYCLES-modulo cycle counter pacing each serial bit.
// tc is combinational from the registered count; pre_tc flags that the next cycle is terminal.
// No backpressure: counts freely unless clear is held.
module bit_timer
    import piso_tx_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tc,
    output logic pre_tc
);

    localparam int CW = (clog2(BIT_CYCLES) > 0) ? clog2(BIT_CYCLES) : 1;

    logic [CW-1:0] count;

    // Count 0..BIT_CYCLES-1 and wrap; clear parks the counter at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || tc) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CW'(BIT_CYCLES - 1));

    // With one-clock bits every cycle is terminal, so the lookahead is constant.
    generate
        if (BIT_CYCLES == 1) begin : g_single
            assign pre_tc = 1'b1;
        end else begin : g_multi
            assign pre_tc = !clear && (count == CW'(BIT_CYCLES - 2));
        end
    endgenerate

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out frame transmitter: start(0), data LSB first, [parity], stop(1).
// Latency: first start-bit clock is the cycle after Load && Ready; each bit held BIT_CYCLES clocks.
// Backpressure: Ready only in IDLE; Load while busy is dropped. Parity bit enabled by PISO_TX_PARITY_EN.
module piso_serial_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] D,
    input  logic             Load,
    output logic             Ready,
    output logic             Q,
    output logic             Busy,
    output logic             Done
);

    localparam int   BW               = clog2(WIDTH + 1);
    localparam logic SINGLE_CYCLE_BIT = (BIT_CYCLES == 1);

    tx_state_t        state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic [BW-1:0]    bit_cnt;
    logic             timer_clear;
    logic             bit_tc;
    logic             bit_pre_tc;
`ifdef PISO_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign shift_next  = shift_reg >> 1;
    assign timer_clear = (state == IDLE);

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk    (CLK),
        .rst    (RST),
        .clear  (timer_clear),
        .tc     (bit_tc),
        .pre_tc (bit_pre_tc)
    );

    // Frame FSM with registered line and handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            Q         <= IDLE_LEVEL;
            Ready     <= 1'b1;
            Busy      <= 1'b0;
            Done      <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Load && Ready) begin
                        shift_reg <= D;
`ifdef PISO_TX_PARITY_EN
                        parity_bit <= ^D;
`endif
                        state <= START;
                        Q     <= START_LEVEL;
                        Ready <= 1'b0;
                        Busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_tc) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        Q       <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_tc) begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(WIDTH - 1)) begin
`ifdef PISO_TX_PARITY_EN
                            state <= PARITY;
                            Q     <= parity_bit;
`else
                            state <= STOP;
                            Q     <= STOP_LEVEL;
                            Done  <= SINGLE_CYCLE_BIT;
`endif
                        end else begin
                            Q <= shift_next[0];
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                PARITY: begin
                    if (bit_tc) begin
                        state <= STOP;
                        Q     <= STOP_LEVEL;
                        Done  <= SINGLE_CYCLE_BIT;
                    end
                end
`endif
                STOP: begin
                    // Done is raised one edge early so it lands on the final stop clock.
                    if (bit_tc) begin
                        state <= IDLE;
                        Q     <= IDLE_LEVEL;
                        Ready <= 1'b1;
                        Busy  <= 1'b0;
                    end else begin
                        Done <= bit_pre_tc;
                    end
                end
                default: begin
                    state <= IDLE;
                    Q     <= IDLE_LEVEL;
                    Ready <= 1'b1;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
